pe_acc: RTL and testbench



---
 rtl/pe_acc.sv | 119 +++++++++++
 tb/tb_pe_acc.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_acc.sv
// Accumulates NUM_BLK consecutive 2x2 partial-product tiles into one output tile
// held in a one-entry valid/ready register. Optional macro PE_ACC_SAT_EN selects saturating adds.
module pe_acc #(
    parameter int IN_W    = 9,
    parameter int ACC_W   = 12,
    parameter int NUM_BLK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_val,
    input  logic [IN_W-1:0]  c11,
    input  logic [IN_W-1:0]  c12,
    input  logic [IN_W-1:0]  c21,
    input  logic [IN_W-1:0]  c22,
    input  logic             clr,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [ACC_W-1:0] d11,
    output logic [ACC_W-1:0] d12,
    output logic [ACC_W-1:0] d21,
    output logic [ACC_W-1:0] d22,
    output logic [7:0]       blk_cnt,
`ifdef PE_ACC_SAT_EN
    output logic             sat,
`endif
    output logic             ovf
);

    localparam logic [7:0] LAST = 8'(NUM_BLK - 1);

    logic [3:0][ACC_W-1:0] acc;
    logic [3:0][ACC_W-1:0] c_ext;
    logic [3:0][ACC_W:0]   wide;
    logic [3:0][ACC_W-1:0] result;
    logic [3:0][ACC_W-1:0] d_reg;
    logic                  first;
    logic                  done;
`ifdef PE_ACC_SAT_EN
    logic [3:0]            sat_flag;
    logic [3:0]            sat_next;
`endif

    assign d11 = d_reg[0];
    assign d12 = d_reg[1];
    assign d21 = d_reg[2];
    assign d22 = d_reg[3];

    // A beat coincident with clr starts a fresh tile, exactly like a beat at blk_cnt==0.
    always_comb begin
        c_ext[0] = ACC_W'(c11);
        c_ext[1] = ACC_W'(c12);
        c_ext[2] = ACC_W'(c21);
        c_ext[3] = ACC_W'(c22);
        first    = clr || (blk_cnt == 8'd0);
        done     = in_val && (first ? (NUM_BLK == 1) : (blk_cnt == LAST));
`ifdef PE_ACC_SAT_EN
        sat_next = 4'b0000;
`endif
        for (int i = 0; i < 4; i++) begin
            wide[i]   = {1'b0, acc[i]} + {1'b0, c_ext[i]};
            result[i] = first ? c_ext[i] : wide[i][ACC_W-1:0];
`ifdef PE_ACC_SAT_EN
            if (!first) begin
                sat_next[i] = sat_flag[i] | wide[i][ACC_W];
                if (wide[i][ACC_W]) begin
                    result[i] = '1;
                end
            end
`endif
        end
    end

    // On completion acc is left alone: the next accepted beat reloads it anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            blk_cnt <= 8'd0;
            out_val <= 1'b0;
            d_reg   <= '0;
            ovf     <= 1'b0;
`ifdef PE_ACC_SAT_EN
            sat_flag <= 4'b0000;
            sat      <= 1'b0;
`endif
        end else begin
            if (in_val) begin
                if (done) begin
                    blk_cnt <= 8'd0;
                end else begin
                    blk_cnt <= first ? 8'd1 : blk_cnt + 8'd1;
                    acc     <= result;
`ifdef PE_ACC_SAT_EN
                    sat_flag <= sat_next;
`endif
                end
            end else if (clr) begin
                blk_cnt <= 8'd0;
`ifdef PE_ACC_SAT_EN
                sat_flag <= 4'b0000;
`endif
            end

            if (done) begin
                if (!out_val || out_rdy) begin
                    d_reg   <= result;
                    out_val <= 1'b1;
`ifdef PE_ACC_SAT_EN
                    sat     <= |sat_next;
`endif
                end else begin
                    ovf <= 1'b1;
                end
            end else if (out_val && out_rdy) begin
                out_val <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pe_acc.sv
// Randomized and directed self-checking bench for pe_acc against a tile-summing reference model.
module tb_pe_acc;

    localparam int IN_W    = 9;
    localparam int ACC_W   = 12;
    localparam int NUM_BLK = 2;
    localparam int MAXV    = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_val = 1'b0;
    logic             clr = 1'b0;
    logic             out_rdy = 1'b0;
    logic [IN_W-1:0]  c11 = '0, c12 = '0, c21 = '0, c22 = '0;
    logic             out_val;
    logic [ACC_W-1:0] d11, d12, d21, d22;
    logic [7:0]       blk_cnt;
    logic             ovf;

    logic             w_in_val = 1'b0;
    logic [IN_W-1:0]  w_c11 = '0;
    logic             w_out_val;
    logic [8:0]       w_d11, w_d12, w_d21, w_d22;
    logic [7:0]       w_blk_cnt;
    logic             w_ovf;
`ifdef PE_ACC_SAT_EN
    logic             sat;
    logic             w_sat;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int m_sum[4];
    int m_d[4];
    int m_cnt;
    bit m_val;
    bit m_ovf;
    bit m_sf;
    bit m_sat;

    always #5 clk = ~clk;

    pe_acc #(.IN_W(IN_W), .ACC_W(ACC_W), .NUM_BLK(NUM_BLK)) dut (
        .clk(clk), .rst(rst), .in_val(in_val),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .clr(clr), .out_val(out_val), .out_rdy(out_rdy),
        .d11(d11), .d12(d12), .d21(d21), .d22(d22),
        .blk_cnt(blk_cnt),
`ifdef PE_ACC_SAT_EN
        .sat(sat),
`endif
        .ovf(ovf)
    );

    // Narrow instance for the wrap/saturation boundary.
    pe_acc #(.IN_W(9), .ACC_W(9), .NUM_BLK(2)) dut_w (
        .clk(clk), .rst(rst), .in_val(w_in_val),
        .c11(w_c11), .c12(9'd0), .c21(9'd0), .c22(9'd0),
        .clr(1'b0), .out_val(w_out_val), .out_rdy(1'b1),
        .d11(w_d11), .d12(w_d12), .d21(w_d21), .d22(w_d22),
        .blk_cnt(w_blk_cnt),
`ifdef PE_ACC_SAT_EN
        .sat(w_sat),
`endif
        .ovf(w_ovf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sum[i] = 0;
            m_d[i]   = 0;
        end
        m_cnt = 0;
        m_val = 0;
        m_ovf = 0;
        m_sf  = 0;
        m_sat = 0;
    endtask

    // Sums beats of a tile with plain integer arithmetic; the tile is done after NUM_BLK beats.
    task automatic model_step(input bit iv, input bit cl, input bit rdy, input int cv[4]);
        bit complete;
        int s;
        complete = 0;
        if (iv) begin
            if (cl || m_cnt == 0) begin
                for (int i = 0; i < 4; i++) m_sum[i] = cv[i];
                m_sf  = 0;
                m_cnt = 0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    s = m_sum[i] + cv[i];
`ifdef PE_ACC_SAT_EN
                    if (s > MAXV) begin
                        s = MAXV;
                        m_sf = 1;
                    end
`else
                    s = s % (MAXV + 1);
`endif
                    m_sum[i] = s;
                end
            end
            m_cnt++;
            if (m_cnt == NUM_BLK) begin
                complete = 1;
                m_cnt = 0;
            end
        end else if (cl) begin
            m_cnt = 0;
        end
        if (complete) begin
            if (!m_val || rdy) begin
                for (int i = 0; i < 4; i++) m_d[i] = m_sum[i];
                m_val = 1;
                m_sat = m_sf;
            end else begin
                m_ovf = 1;
            end
        end else if (m_val && rdy) begin
            m_val = 0;
        end
    endtask

    task automatic compare_all();
        checkOutput("out_val", 32'(out_val), 32'(m_val));
        checkOutput("blk_cnt", 32'(blk_cnt), 32'(m_cnt));
        checkOutput("ovf", 32'(ovf), 32'(m_ovf));
        checkOutput("d11", 32'(d11), 32'(m_d[0]));
        checkOutput("d12", 32'(d12), 32'(m_d[1]));
        checkOutput("d21", 32'(d21), 32'(m_d[2]));
        checkOutput("d22", 32'(d22), 32'(m_d[3]));
`ifdef PE_ACC_SAT_EN
        checkOutput("sat", 32'(sat), 32'(m_sat));
`endif
    endtask

    // Drives one cycle of inputs, advances the model, then checks just after the edge.
    task automatic applyStimulus(input bit iv, input bit cl, input bit rdy,
                                 input int a, input int b, input int c, input int d);
        int cv[4];
        cv[0] = a; cv[1] = b; cv[2] = c; cv[3] = d;
        in_val  = iv;
        clr     = cl;
        out_rdy = rdy;
        c11 = IN_W'(a); c12 = IN_W'(b); c21 = IN_W'(c); c22 = IN_W'(d);
        model_step(iv, cl, rdy, cv);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        model_reset();
        #12;
        compare_all();
        @(posedge clk);
        #1 rst = 1'b0;

        // Two-beat tile with immediate consumption.
        applyStimulus(1, 0, 1, 3, 5, 7, 9);
        checkOutput("plan_cnt1", 32'(blk_cnt), 32'd1);
        applyStimulus(1, 0, 1, 10, 20, 30, 40);
        checkOutput("plan_val", 32'(out_val), 32'd1);
        checkOutput("plan_d11", 32'(d11), 32'd13);
        checkOutput("plan_d22", 32'(d22), 32'd49);
        checkOutput("plan_cnt0", 32'(blk_cnt), 32'd0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("plan_val_drop", 32'(out_val), 32'd0);

        // Streaming: four tiles of ones.
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 1, 1, 1, 1, 1);
        checkOutput("stream_d12", 32'(d12), 32'd2);
        checkOutput("stream_ovf", 32'(ovf), 32'd0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);

        // Backpressure: second tile is dropped.
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 1, 1, 1, 1);
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 5, 5, 5, 5);
        checkOutput("bp_hold_d11", 32'(d11), 32'd2);
        checkOutput("bp_ovf", 32'(ovf), 32'd1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("bp_val_drop", 32'(out_val), 32'd0);
        checkOutput("bp_ovf_sticky", 32'(ovf), 32'd1);

        // clr alone, then clr coincident with the first beat.
        applyStimulus(1, 0, 1, 100, 100, 100, 100);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 2, 3, 4);
        applyStimulus(1, 0, 1, 1, 2, 3, 4);
        checkOutput("clr_d21", 32'(d21), 32'd6);
        applyStimulus(1, 0, 1, 100, 100, 100, 100);
        applyStimulus(1, 1, 1, 1, 2, 3, 4);
        checkOutput("clr_co_cnt", 32'(blk_cnt), 32'd1);
        applyStimulus(1, 0, 1, 1, 2, 3, 4);
        checkOutput("clr_co_d22", 32'(d22), 32'd8);

        // Wrap/saturate on the narrow instance.
        w_in_val = 1'b1;
        w_c11    = 9'd511;
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        w_in_val = 1'b0;
        checkOutput("w_val", 32'(w_out_val), 32'd1);
`ifdef PE_ACC_SAT_EN
        checkOutput("w_d11", 32'(w_d11), 32'd511);
        checkOutput("w_sat", 32'(w_sat), 32'd1);
`else
        checkOutput("w_d11", 32'(w_d11), 32'd510);
`endif

        // Async reset mid-tile with a pending output.
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 7, 7, 7, 7);
        applyStimulus(1, 0, 0, 9, 9, 9, 9);
        #2 rst = 1'b1;
        #1;
        model_reset();
        checkOutput("rst_val", 32'(out_val), 32'd0);
        checkOutput("rst_cnt", 32'(blk_cnt), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        #2 rst = 1'b0;
        applyStimulus(1, 0, 1, 1, 1, 1, 1);
        applyStimulus(1, 0, 1, 1, 1, 1, 1);
        checkOutput("rst_after_d11", 32'(d11), 32'd2);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 9) < 6,
                          int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                          int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
